hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/cpu_core_params.sv | 11 +
 rtl/hazard_scoreboard.sv | 165 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_params.sv
// Shared core-wide parameters used across the CPU pipeline.
//   REG_ADDR_WIDTH : architectural register index width
//   REG_COUNT      : number of architectural registers
//   X0_INDEX       : index of the hardwired-zero register
package cpu_core_params;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_COUNT      = 32;
  localparam int unsigned X0_INDEX       = 0;

endpackage

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for the decode stage.
//
// Tracks, per architectural register, how many issued but not yet retired
// instructions will write it, and holds the decode instruction back while any
// used source is pending or while the writer capacity is exhausted.
//
// Ports:
//   i_Clock            rising-edge clock
//   w_Reset            synchronous active-high reset
//   i_Issue_*          decode-stage instruction (sources, destination, valid)
//   o_Issue_Ready      presented instruction may advance this cycle
//   i_Wb_Valid/Rd      writeback retirement of one writer
//   i_Kill_Valid/Rd    squash of one in-flight writer by a flush
//   o_Inflight_Count   total outstanding writers
//   o_Empty            no outstanding writers
//   o_Error            sticky: a retire/kill hit a register with no pending writer
//
// Build option:
//   SCOREBOARD_BYPASS_EN  when defined, a source whose only pending writer is
//                         retiring this cycle is not a hazard (data forwarded).
module hazard_scoreboard #(
  parameter int unsigned REG_COUNT      = cpu_core_params::REG_COUNT,
  parameter int unsigned REG_ADDR_WIDTH = cpu_core_params::REG_ADDR_WIDTH,
  parameter int unsigned MAX_INFLIGHT   = 4,
  localparam int unsigned CNT_W         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                      i_Clock,
  input  logic                      w_Reset,
  input  logic                      i_Issue_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_Issue_Rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_Issue_Rs2,
  input  logic                      i_Issue_Rs1_Used,
  input  logic                      i_Issue_Rs2_Used,
  input  logic [REG_ADDR_WIDTH-1:0] i_Issue_Rd,
  input  logic                      i_Issue_Rd_Write,
  output logic                      o_Issue_Ready,
  input  logic                      i_Wb_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_Wb_Rd,
  input  logic                      i_Kill_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_Kill_Rd,
  output logic [CNT_W-1:0]          o_Inflight_Count,
  output logic                      o_Empty,
  output logic                      o_Error
);

  localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(cpu_core_params::X0_INDEX);
  localparam logic [CNT_W-1:0]          CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]    cnt_q [REG_COUNT];
  logic [1:0]          eff_dec [REG_COUNT];
  logic [REG_COUNT-1:0] underflow;

  logic [CNT_W-1:0]    total_q;
  logic [CNT_W+1:0]    total_calc;
  logic [CNT_W+1:0]    dec_sum;
  logic                error_q;
  logic                issue_fire;

  logic [CNT_W-1:0]    rs1_cnt;
  logic [CNT_W-1:0]    rs2_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic                rs1_fwd;
  logic                rs2_fwd;
  logic                rs1_haz;
  logic                rs2_haz;
  logic                rd_writes;

  assign rs1_cnt   = cnt_q[i_Issue_Rs1];
  assign rs2_cnt   = cnt_q[i_Issue_Rs2];
  assign rd_cnt    = cnt_q[i_Issue_Rd];
  assign rd_writes = i_Issue_Rd_Write && (i_Issue_Rd != X0);

`ifdef SCOREBOARD_BYPASS_EN
  // Only safe when the retiring writer is the last one pending on that register.
  assign rs1_fwd = i_Wb_Valid && (i_Wb_Rd == i_Issue_Rs1) && (rs1_cnt == CNT_W'(1));
  assign rs2_fwd = i_Wb_Valid && (i_Wb_Rd == i_Issue_Rs2) && (rs2_cnt == CNT_W'(1));
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
`endif

  // Register 0 never holds a nonzero counter, so x0 sources never stall.
  assign rs1_haz = i_Issue_Rs1_Used && (rs1_cnt != '0) && !rs1_fwd;
  assign rs2_haz = i_Issue_Rs2_Used && (rs2_cnt != '0) && !rs2_fwd;

  always_comb begin
    o_Issue_Ready = 1'b1;
    if (rs1_haz || rs2_haz) begin
      o_Issue_Ready = 1'b0;
    end
    if (rd_writes && ((total_q == CNT_MAX) || (rd_cnt == CNT_MAX))) begin
      o_Issue_Ready = 1'b0;
    end
  end

  assign issue_fire = i_Issue_Valid && o_Issue_Ready && rd_writes;

  // Per-register counters; issue, writeback and kill fold into one net update.
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
    if (g == cpu_core_params::X0_INDEX) begin : g_zero
      assign cnt_q[g]     = '0;
      assign eff_dec[g]   = 2'd0;
      assign underflow[g] = 1'b0;
    end else begin : g_cnt
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_n;
      logic [CNT_W:0]   avail;
      logic [1:0]       req;
      logic             inc;
      logic             uf;

      assign inc = issue_fire && (i_Issue_Rd == REG_ADDR_WIDTH'(g));

      always_comb begin
        avail = {1'b0, cnt_r} + (CNT_W + 1)'(inc);
        req   = {1'b0, i_Wb_Valid && (i_Wb_Rd == REG_ADDR_WIDTH'(g))}
              + {1'b0, i_Kill_Valid && (i_Kill_Rd == REG_ADDR_WIDTH'(g))};
        uf    = 1'b0;
        cnt_n = cnt_r;
        if (avail >= (CNT_W + 1)'(req)) begin
          cnt_n = CNT_W'(avail - (CNT_W + 1)'(req));
        end else begin
          // Saturate at zero; only what was actually pending leaves the total.
          cnt_n = '0;
          uf    = 1'b1;
        end
      end

      always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_n;
        end
      end

      assign cnt_q[g]     = cnt_r;
      assign eff_dec[g]   = uf ? avail[1:0] : req;
      assign underflow[g] = uf;
    end
  end

  always_comb begin
    dec_sum = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      dec_sum = dec_sum + (CNT_W + 2)'(eff_dec[i]);
    end
    total_calc = {2'b00, total_q} + (CNT_W + 2)'(issue_fire) - dec_sum;
  end

  always_ff @(posedge i_Clock) begin
    if (w_Reset) begin
      total_q <= '0;
      error_q <= 1'b0;
    end else begin
      total_q <= CNT_W'(total_calc);
      error_q <= error_q || (underflow != '0);
    end
  end

  assign o_Inflight_Count = total_q;
  assign o_Empty          = (total_q == '0);
  assign o_Error          = error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters.
module tb_hazard_scoreboard;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 3;

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          iss_valid;
  logic [AW-1:0] iss_rs1;
  logic [AW-1:0] iss_rs2;
  logic          iss_rs1_used;
  logic          iss_rs2_used;
  logic [AW-1:0] iss_rd;
  logic          iss_rd_write;
  logic          ready;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic          kill_valid;
  logic [AW-1:0] kill_rd;
  logic [CW-1:0] count;
  logic          empty;
  logic          error;

  int tests;
  int fails;

  hazard_scoreboard dut (
    .i_Clock          (clk),
    .w_Reset          (rst),
    .i_Issue_Valid    (iss_valid),
    .i_Issue_Rs1      (iss_rs1),
    .i_Issue_Rs2      (iss_rs2),
    .i_Issue_Rs1_Used (iss_rs1_used),
    .i_Issue_Rs2_Used (iss_rs2_used),
    .i_Issue_Rd       (iss_rd),
    .i_Issue_Rd_Write (iss_rd_write),
    .o_Issue_Ready    (ready),
    .i_Wb_Valid       (wb_valid),
    .i_Wb_Rd          (wb_rd),
    .i_Kill_Valid     (kill_valid),
    .i_Kill_Rd        (kill_rd),
    .o_Inflight_Count (count),
    .o_Empty          (empty),
    .o_Error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rs1_used = 1'b0;
    iss_rs2_used = 1'b0; iss_rd = '0; iss_rd_write = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; kill_valid = 1'b0; kill_rd = '0;
  endtask

  task automatic issue_wr(input logic [AW-1:0] rd);
    idle();
    iss_valid = 1'b1; iss_rd = rd; iss_rd_write = 1'b1;
  endtask

  task automatic issue_src(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic u1, input logic u2);
    idle();
    iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rs1_used = u1; iss_rs2_used = u2;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_count", count, 0);
    check("reset_empty", empty, 1);
    check("reset_error", error, 0);
    check("reset_ready", ready, 1);

    // RAW stall on x5
    issue_wr(5'd5);
    #1 check("raw_issue_ready", ready, 1);
    tick();
    issue_src(5'd5, 5'd0, 1'b1, 1'b0);
    #1 check("raw_stall", ready, 0);
    check("raw_count", count, 1);
    check("raw_not_empty", empty, 0);
    tick();
    #1 check("raw_stall_hold", ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1 check("raw_wb_cycle", ready, 32'(BYP));
    tick();
    wb_valid = 1'b0;
    #1 check("raw_after_wb", ready, 1);
    check("raw_after_wb_count", count, 0);

    // Capacity: four writers fill the scoreboard
    for (int r = 1; r <= 4; r++) begin
      issue_wr(5'(r));
      #1 check("cap_fill_ready", ready, 1);
      tick();
    end
    check("cap_full_count", count, 4);
    issue_wr(5'd6);
    #1 check("cap_fifth_stall", ready, 0);
    tick();
    check("cap_no_fire", count, 4);
    wb_valid = 1'b1; wb_rd = 5'd1;
    tick();
    wb_valid = 1'b0;
    #1 check("cap_after_wb_ready", ready, 1);
    check("cap_after_wb_count", count, 3);
    tick();
    check("cap_fifth_fired", count, 4);
    idle();
    for (int r = 2; r <= 6; r++) begin
      if (r != 5) begin
        wb_valid = 1'b1; wb_rd = 5'(r);
        tick();
      end
    end
    idle();
    check("cap_drained", count, 0);

    // Simultaneous issue and writeback on x7
    issue_wr(5'd7);
    tick();
    check("sim_pre_count", count, 1);
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1 check("sim_ready", ready, 1);
    tick();
    check("sim_total", count, 1);
    issue_src(5'd7, 5'd0, 1'b1, 1'b0);
    #1 check("sim_x7_pending", ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    wb_valid = 1'b0;
    #1 check("sim_x7_was_one", ready, 1);
    check("sim_x7_count", count, 0);

    // x0 is never tracked
    for (int k = 0; k < 10; k++) begin
      issue_wr(5'd0);
      tick();
    end
    idle();
    check("x0_count", count, 0);
    check("x0_empty", empty, 1);
    issue_src(5'd0, 5'd0, 1'b1, 1'b1);
    #1 check("x0_ready", ready, 1);
    idle();
    wb_valid = 1'b1; kill_valid = 1'b1;
    tick();
    idle();
    check("x0_wb_kill_no_error", error, 0);

    // Kill retires a writer like writeback
    issue_wr(5'd8);
    tick();
    idle();
    kill_valid = 1'b1; kill_rd = 5'd8;
    tick();
    idle();
    check("kill_count", count, 0);
    check("kill_no_error", error, 0);

    // Bypass on rs2 = x9
    issue_wr(5'd9);
    tick();
    issue_src(5'd0, 5'd9, 1'b0, 1'b1);
    #1 check("byp_stall_no_wb", ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd9;
    #1 check("byp_same_cycle", ready, 32'(BYP));
    tick();
    idle();
    check("byp_count", count, 0);

    // Underflow is sticky
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    idle();
    check("uf_error", error, 1);
    check("uf_count", count, 0);
    tick();
    check("uf_error_held", error, 1);

    // Reset mid-stream wins over a concurrent issue
    for (int r = 10; r <= 12; r++) begin
      issue_wr(5'(r));
      tick();
    end
    check("mid_count", count, 3);
    issue_wr(5'd13);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_error", error, 0);
    issue_src(5'd10, 5'd13, 1'b1, 1'b1);
    #1 check("mid_rst_ready", ready, 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
